// File: rtl/conv_pkg.sv
// Shared constants and types for the convolution output write-back stages.
// Per-layer geometry lives here so each layer's writer instance stays consistent with its BRAM map.
package conv_pkg;

  localparam int CONV1_CH        = 16;
  localparam int CONV1_DW        = 8;
  localparam int CONV1_DEPTH     = 1260;
  localparam int CONV1_AW        = 11;
  localparam int CONV1_BASE_ADDR = 0;

  localparam int CONV2_CH        = 32;
  localparam int CONV2_DW        = 8;
  localparam int CONV2_DEPTH     = 392;
  localparam int CONV2_AW        = 11;
  localparam int CONV2_BASE_ADDR = 1260;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } conv_state_e;

  // True when a frame of depth words starting at base_addr fits in an aw-bit address space.
  function automatic bit conv_addr_fits(input int base_addr, input int depth, input int aw);
    return (depth >= 1) && (base_addr >= 0) &&
           ((longint'(base_addr) + longint'(depth)) <= (longint'(1) << aw));
  endfunction

endpackage

// File: rtl/conv_out_writer_if.sv
// Conv result stream plus BRAM write port of one write-back stage.
// master = producer / BRAM observer side, slave = the writer itself.
interface conv_out_writer_if #(
  parameter int CH = 16,
  parameter int DW = 8,
  parameter int AW = 11
);

  logic                 in_valid;
  logic [CH*DW-1:0]     in_data;
  logic                 ena;
  logic                 wea;
  logic [AW-1:0]        addra;
  logic [CH*DW-1:0]     dina;

  modport master (
    output in_valid, in_data,
    input  ena, wea, addra, dina
  );

  modport slave (
    input  in_valid, in_data,
    output ena, wea, addra, dina
  );

endinterface

// File: rtl/conv_lane_relu.sv
// One lane of optional ReLU: negative two's-complement values clamp to zero.
module conv_lane_relu #(
  parameter int DW   = 8,
  parameter int RELU = 0
) (
  input  logic [DW-1:0] lane_in,
  output logic [DW-1:0] lane_out
);

  // Clamp on sign bit when ReLU is enabled, otherwise pass through
  always_comb begin
    if ((RELU != 0) && lane_in[DW-1]) begin
      lane_out = {DW{1'b0}};
    end else begin
      lane_out = lane_in;
    end
  end

endmodule

// File: rtl/conv_out_writer.sv
// Write-back stage: one registered BRAM write per accepted conv output vector,
// consecutive addresses from BASE_ADDR, with frame restart, completion and overflow status.
module conv_out_writer
  import conv_pkg::*;
#(
  parameter int CH        = 16,
  parameter int DW        = 8,
  parameter int DEPTH     = 1260,
  parameter int AW        = 11,
  parameter int BASE_ADDR = 0,
  parameter int RELU      = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  conv_out_writer_if.slave    bus,
  output logic                busy,
  output logic                done,
  output logic                overflow,
  output logic [AW-1:0]       wr_count
);

  localparam int            W        = CH * DW;
  localparam logic [AW-1:0] LAST_CNT = AW'(DEPTH - 1);
  localparam logic [AW-1:0] BASE     = AW'(BASE_ADDR);
  localparam logic [AW-1:0] ONE      = AW'(1);

  generate
    if (!conv_addr_fits(BASE_ADDR, DEPTH, AW)) begin : g_addr_chk
      $error("conv_out_writer: BASE_ADDR+DEPTH-1 does not fit in AW address bits");
    end
  endgenerate

  conv_state_e   state_r, state_nxt_s;
  logic [AW-1:0] cnt_r, cnt_nxt_s;
  logic          ovf_r, ovf_nxt_s;
  logic          wr_s;
  logic          ena_r, busy_r, done_r;
  logic [AW-1:0] addra_r;
  logic [W-1:0]  dina_r;
  logic [W-1:0]  proc_data_s;

  genvar k;
  generate
    for (k = 0; k < CH; k++) begin : g_lane
      conv_lane_relu #(.DW(DW), .RELU(RELU)) u_lane (
        .lane_in  (bus.in_data[k*DW +: DW]),
        .lane_out (proc_data_s[k*DW +: DW])
      );
    end
  endgenerate

  // Next-state, counter and overflow decisions; start always wins over in_valid
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    ovf_nxt_s   = ovf_r;
    wr_s        = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nxt_s = RUN;
          cnt_nxt_s   = {AW{1'b0}};
          ovf_nxt_s   = 1'b0;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (start) begin
          cnt_nxt_s = {AW{1'b0}};
        end else if (bus.in_valid) begin
          wr_s      = 1'b1;
          cnt_nxt_s = cnt_r + ONE;
          if (cnt_r == LAST_CNT) begin
            state_nxt_s = DONE;
          end else begin
            state_nxt_s = RUN;
          end
        end else begin
          state_nxt_s = RUN;
        end
      end
      DONE: begin
        if (start) begin
          state_nxt_s = RUN;
          cnt_nxt_s   = {AW{1'b0}};
          ovf_nxt_s   = 1'b0;
        end else if (bus.in_valid) begin
          ovf_nxt_s = 1'b1;
        end else begin
          ovf_nxt_s = ovf_r;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = {AW{1'b0}};
        ovf_nxt_s   = 1'b0;
      end
    endcase
  end

  // FSM state, write counter and sticky overflow
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
      cnt_r   <= {AW{1'b0}};
      ovf_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      ovf_r   <= ovf_nxt_s;
    end
  end

  // Registered BRAM port and status; address/data hold between writes
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ena_r   <= 1'b0;
      addra_r <= {AW{1'b0}};
      dina_r  <= {W{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      ena_r  <= wr_s;
      busy_r <= (state_nxt_s == RUN);
      done_r <= (state_nxt_s == DONE);
      if (wr_s) begin
        addra_r <= BASE + cnt_r;
        dina_r  <= proc_data_s;
      end else begin
        addra_r <= addra_r;
        dina_r  <= dina_r;
      end
    end
  end

  assign bus.ena   = ena_r;
  assign bus.wea   = ena_r;
  assign bus.addra = addra_r;
  assign bus.dina  = dina_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign overflow  = ovf_r;
  assign wr_count  = cnt_r;

endmodule

// File: tb/tb_conv_out_writer.sv
// Scoreboard bench for conv_out_writer: a full-size pass-through instance (A) and a
// small ReLU instance at a non-zero base (B), each with its own reference model.
module tb_conv_out_writer;
  import conv_pkg::*;

  localparam int CH = 16;
  localparam int DW = 8;
  localparam int W  = CH * DW;
  localparam int AW = 11;
  localparam int DEPTH_A = 1260;
  localparam int BASE_A  = 0;
  localparam int RELU_A  = 0;
  localparam int DEPTH_B = 4;
  localparam int BASE_B  = 100;
  localparam int RELU_B  = 1;

  typedef struct {
    logic [AW-1:0] addr;
    logic [W-1:0]  data;
  } wr_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          start_a, start_b;
  logic          busy_a, done_a, ovf_a, busy_b, done_b, ovf_b;
  logic [AW-1:0] cnt_a, cnt_b;

  conv_out_writer_if #(.CH(CH), .DW(DW), .AW(AW)) ifa ();
  conv_out_writer_if #(.CH(CH), .DW(DW), .AW(AW)) ifb ();

  conv_out_writer #(.CH(CH), .DW(DW), .DEPTH(DEPTH_A), .AW(AW), .BASE_ADDR(BASE_A), .RELU(RELU_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .bus(ifa.slave),
    .busy(busy_a), .done(done_a), .overflow(ovf_a), .wr_count(cnt_a)
  );

  conv_out_writer #(.CH(CH), .DW(DW), .DEPTH(DEPTH_B), .AW(AW), .BASE_ADDR(BASE_B), .RELU(RELU_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .bus(ifb.slave),
    .busy(busy_b), .done(done_b), .overflow(ovf_b), .wr_count(cnt_b)
  );

  wr_t qa[$];
  wr_t qb[$];
  int  checks = 0;
  int  failures = 0;

  // Reference model state: 0 idle, 1 run, 2 done
  int ma_st = 0, ma_cnt = 0, mb_st = 0, mb_cnt = 0;
  bit ma_ovf = 1'b0, mb_ovf = 1'b0;

  function automatic logic [W-1:0] relu_f(input logic [W-1:0] d, input int en);
    logic [W-1:0] r;
    r = d;
    if (en != 0) begin
      for (int k = 0; k < CH; k++) begin
        if (d[k*DW + DW - 1]) r[k*DW +: DW] = 8'h00;
      end
    end
    return r;
  endfunction

  function automatic logic [W-1:0] rand_data();
    logic [W-1:0] r;
    for (int k = 0; k < W / 32; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic step_a(input bit s, input bit v, input logic [W-1:0] d, output bit exp);
    wr_t w;
    exp = 1'b0;
    start_a = s; ifa.in_valid = v; ifa.in_data = d;
    if (s) begin
      ma_st = 1; ma_cnt = 0; ma_ovf = 1'b0;
    end else if (v && ma_st == 1) begin
      w.addr = AW'(BASE_A + ma_cnt);
      w.data = relu_f(d, RELU_A);
      qa.push_back(w);
      exp = 1'b1;
      ma_cnt++;
      if (ma_cnt == DEPTH_A) ma_st = 2;
    end else if (v && ma_st == 2) begin
      ma_ovf = 1'b1;
    end
    @(posedge clk); #1;
    start_a = 1'b0; ifa.in_valid = 1'b0;
  endtask

  task automatic step_b(input bit s, input bit v, input logic [W-1:0] d, output bit exp);
    wr_t w;
    exp = 1'b0;
    start_b = s; ifb.in_valid = v; ifb.in_data = d;
    if (s) begin
      mb_st = 1; mb_cnt = 0; mb_ovf = 1'b0;
    end else if (v && mb_st == 1) begin
      w.addr = AW'(BASE_B + mb_cnt);
      w.data = relu_f(d, RELU_B);
      qb.push_back(w);
      exp = 1'b1;
      mb_cnt++;
      if (mb_cnt == DEPTH_B) mb_st = 2;
    end else if (v && mb_st == 2) begin
      mb_ovf = 1'b1;
    end
    @(posedge clk); #1;
    start_b = 1'b0; ifb.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    start_a = 1'b0; start_b = 1'b0;
    ifa.in_valid = 1'b0; ifa.in_data = '0;
    ifb.in_valid = 1'b0; ifb.in_data = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    checks++;
    if ({ifa.ena, ifa.wea, busy_a, done_a, ovf_a} !== 5'b0 || ifa.addra !== 11'd0 ||
        ifa.dina !== 128'd0 || cnt_a !== 11'd0) begin
      failures++;
      $display("FAIL reset_a ena=%b busy=%b done=%b ovf=%b addr=%0d cnt=%0d dina=%h required all zero",
               ifa.ena, busy_a, done_a, ovf_a, ifa.addra, cnt_a, ifa.dina);
    end
    checks++;
    if ({ifb.ena, ifb.wea, busy_b, done_b, ovf_b} !== 5'b0 || ifb.addra !== 11'd0 ||
        ifb.dina !== 128'd0 || cnt_b !== 11'd0) begin
      failures++;
      $display("FAIL reset_b ena=%b busy=%b done=%b ovf=%b addr=%0d cnt=%0d required all zero",
               ifb.ena, busy_b, done_b, ovf_b, ifb.addra, cnt_b);
    end
  endtask

  task automatic test_idle_ignore();
    bit e;
    for (int i = 0; i < 3; i++) begin
      step_a(1'b0, 1'b1, rand_data(), e);
      checks++;
      if (ifa.ena !== 1'b0 || busy_a !== 1'b0 || cnt_a !== 11'd0) begin
        failures++;
        $display("FAIL idle_ignore ena=%b busy=%b cnt=%0d required 0 0 0", ifa.ena, busy_a, cnt_a);
      end
    end
  endtask

  task automatic test_full_frame();
    bit e;
    wr_t w;
    logic [W-1:0] d;
    for (int k = 0; k < CH; k++) d[k*DW +: DW] = 8'(k);
    step_a(1'b1, 1'b0, d, e);
    checks++;
    if (busy_a !== 1'b1 || done_a !== 1'b0 || cnt_a !== 11'd0) begin
      failures++;
      $display("FAIL frame_start busy=%b done=%b cnt=%0d required 1 0 0", busy_a, done_a, cnt_a);
    end
    for (int i = 0; i < DEPTH_A; i++) begin
      step_a(1'b0, 1'b1, d, e);
      if (e) begin
        w = qa.pop_front();
        checks++;
        if (ifa.ena !== 1'b1 || ifa.wea !== 1'b1 || ifa.addra !== w.addr || ifa.dina !== w.data) begin
          failures++;
          $display("FAIL frame_write ena=%b wea=%b addr=%0d dina=%h required addr=%0d dina=%h",
                   ifa.ena, ifa.wea, ifa.addra, ifa.dina, w.addr, w.data);
        end
      end
      checks++;
      if (busy_a !== (ma_st == 1) || done_a !== (ma_st == 2) || cnt_a !== AW'(ma_cnt)) begin
        failures++;
        $display("FAIL frame_status i=%0d busy=%b done=%b cnt=%0d required busy=%b done=%b cnt=%0d",
                 i, busy_a, done_a, cnt_a, ma_st == 1, ma_st == 2, ma_cnt);
      end
    end
    checks++;
    if (ifa.addra !== 11'd1259 || done_a !== 1'b1 || busy_a !== 1'b0 || ifa.ena !== 1'b1) begin
      failures++;
      $display("FAIL frame_last addr=%0d done=%b busy=%b ena=%b required 1259 1 0 1",
               ifa.addra, done_a, busy_a, ifa.ena);
    end
    step_a(1'b0, 1'b0, d, e);
    checks++;
    if (ifa.ena !== 1'b0 || done_a !== 1'b1) begin
      failures++;
      $display("FAIL frame_after ena=%b done=%b required 0 1", ifa.ena, done_a);
    end
  endtask

  task automatic test_overflow();
    bit e;
    wr_t w;
    for (int i = 0; i < 3; i++) begin
      step_a(1'b0, (i < 2), rand_data(), e);
      checks++;
      if (e || ifa.ena !== 1'b0 || ovf_a !== 1'b1 || done_a !== 1'b1) begin
        failures++;
        $display("FAIL overflow i=%0d ena=%b ovf=%b done=%b required 0 1 1", i, ifa.ena, ovf_a, done_a);
      end
    end
    step_a(1'b1, 1'b0, '0, e);
    checks++;
    if (ovf_a !== 1'b0 || busy_a !== 1'b1 || done_a !== 1'b0 || cnt_a !== 11'd0) begin
      failures++;
      $display("FAIL overflow_clear ovf=%b busy=%b done=%b cnt=%0d required 0 1 0 0",
               ovf_a, busy_a, done_a, cnt_a);
    end
    step_a(1'b0, 1'b1, rand_data(), e);
    w = qa.pop_front();
    checks++;
    if (ifa.ena !== 1'b1 || ifa.addra !== 11'(BASE_A) || ifa.dina !== w.data || w.addr !== ifa.addra) begin
      failures++;
      $display("FAIL overflow_restart ena=%b addr=%0d required 1 %0d", ifa.ena, ifa.addra, BASE_A);
    end
  endtask

  task automatic test_passthru();
    bit e;
    logic [W-1:0] d;
    d = rand_data();
    d[23:0] = 24'hFF7F80;
    step_a(1'b1, 1'b0, '0, e);
    step_a(1'b0, 1'b1, d, e);
    void'(qa.pop_front());
    checks++;
    if (ifa.ena !== 1'b1 || ifa.dina !== d || ifa.addra !== 11'(BASE_A)) begin
      failures++;
      $display("FAIL passthru ena=%b dina=%h addr=%0d required 1 %h %0d", ifa.ena, ifa.dina, ifa.addra, d, BASE_A);
    end
  endtask

  task automatic test_abort();
    bit e;
    wr_t w;
    step_a(1'b1, 1'b0, '0, e);
    for (int i = 0; i < 5; i++) begin
      step_a(1'b0, 1'b1, rand_data(), e);
      w = qa.pop_front();
      checks++;
      if (ifa.ena !== 1'b1 || ifa.addra !== w.addr || ifa.dina !== w.data) begin
        failures++;
        $display("FAIL abort_pre ena=%b addr=%0d required 1 %0d", ifa.ena, ifa.addra, w.addr);
      end
    end
    step_a(1'b1, 1'b1, rand_data(), e);
    checks++;
    if (e || ifa.ena !== 1'b0 || cnt_a !== 11'd0 || busy_a !== 1'b1) begin
      failures++;
      $display("FAIL abort_same_cycle ena=%b cnt=%0d busy=%b required 0 0 1", ifa.ena, cnt_a, busy_a);
    end
    step_a(1'b0, 1'b1, rand_data(), e);
    w = qa.pop_front();
    checks++;
    if (ifa.ena !== 1'b1 || ifa.addra !== 11'(BASE_A) || ifa.dina !== w.data || cnt_a !== 11'd1) begin
      failures++;
      $display("FAIL abort_next ena=%b addr=%0d cnt=%0d required 1 %0d 1", ifa.ena, ifa.addra, cnt_a, BASE_A);
    end
  endtask

  task automatic test_reset_midframe();
    bit e;
    step_a(1'b0, 1'b1, rand_data(), e);
    void'(qa.pop_front());
    ifa.in_valid = 1'b1; ifa.in_data = rand_data();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; ifa.in_valid = 1'b0;
    ma_st = 0; ma_cnt = 0; ma_ovf = 1'b0; mb_st = 0; mb_cnt = 0; mb_ovf = 1'b0;
    qa.delete(); qb.delete();
    checks++;
    if ({ifa.ena, ifa.wea, busy_a, done_a, ovf_a} !== 5'b0 || ifa.addra !== 11'd0 ||
        ifa.dina !== 128'd0 || cnt_a !== 11'd0) begin
      failures++;
      $display("FAIL midframe_reset ena=%b busy=%b done=%b ovf=%b addr=%0d cnt=%0d required all zero",
               ifa.ena, busy_a, done_a, ovf_a, ifa.addra, cnt_a);
    end
    for (int i = 0; i < 3; i++) begin
      step_a(1'b0, 1'b1, rand_data(), e);
      checks++;
      if (e || ifa.ena !== 1'b0 || busy_a !== 1'b0 || cnt_a !== 11'd0) begin
        failures++;
        $display("FAIL midframe_ignore ena=%b busy=%b cnt=%0d required 0 0 0", ifa.ena, busy_a, cnt_a);
      end
    end
  endtask

  task automatic test_sparse_relu();
    bit e;
    wr_t w;
    logic [W-1:0] d;
    int nwr;
    nwr = 0;
    step_b(1'b1, 1'b0, '0, e);
    for (int i = 0; i < 12; i++) begin
      d = rand_data();
      d[23:0] = 24'hFF7F80;
      step_b(1'b0, (i % 3 == 0), d, e);
      if (e) begin
        w = qb.pop_front();
        checks++;
        if (ifb.ena !== 1'b1 || ifb.wea !== 1'b1 || ifb.addra !== 11'(BASE_B + nwr) || ifb.dina !== w.data) begin
          failures++;
          $display("FAIL sparse_write ena=%b addr=%0d dina=%h required addr=%0d dina=%h",
                   ifb.ena, ifb.addra, ifb.dina, BASE_B + nwr, w.data);
        end
        checks++;
        if (ifb.dina[23:0] !== 24'h007F00) begin
          failures++;
          $display("FAIL relu_lanes got=%h required 007f00", ifb.dina[23:0]);
        end
        nwr++;
      end else begin
        checks++;
        if (ifb.ena !== 1'b0) begin
          failures++;
          $display("FAIL sparse_gap i=%0d ena=%b required 0", i, ifb.ena);
        end
      end
      checks++;
      if (busy_b !== (mb_st == 1) || done_b !== (mb_st == 2) || cnt_b !== AW'(mb_cnt) || ovf_b !== mb_ovf) begin
        failures++;
        $display("FAIL sparse_status i=%0d busy=%b done=%b cnt=%0d ovf=%b required %b %b %0d %b",
                 i, busy_b, done_b, cnt_b, ovf_b, mb_st == 1, mb_st == 2, mb_cnt, mb_ovf);
      end
    end
    checks++;
    if (nwr != 4 || done_b !== 1'b1 || ifb.addra !== 11'd103) begin
      failures++;
      $display("FAIL sparse_end writes=%0d done=%b addr=%0d required 4 1 103", nwr, done_b, ifb.addra);
    end
  endtask

  initial begin
    test_reset();
    test_idle_ignore();
    test_full_frame();
    test_overflow();
    test_passthru();
    test_abort();
    test_reset_midframe();
    test_sparse_relu();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
